// File: rtl/coco_cp0_pkg.sv
// -----------------------------------------------------------------------------
// coco_cp0_pkg
// Shared CP0 definitions for the Coco MIPS core:
//   - CP0 register index constants (SR, CAUSE, EPC, PRID)
//   - Exception code constants (INT, SYS, RI, OV)
//   - State enum for the exception/interrupt sequencer (coco_exc_ctrl)
//   - Helper mapping a synchronous exception request vector to its code
// -----------------------------------------------------------------------------
package coco_cp0_pkg;

    // CP0 register indices
    localparam logic [4:0] CP0_IDX_SR    = 5'd12;
    localparam logic [4:0] CP0_IDX_CAUSE = 5'd13;
    localparam logic [4:0] CP0_IDX_EPC   = 5'd14;
    localparam logic [4:0] CP0_IDX_PRID  = 5'd15;

    // Exception codes as written to Cause.ExcCode
    localparam logic [4:0] EXC_CODE_INT = 5'd0;
    localparam logic [4:0] EXC_CODE_SYS = 5'd8;
    localparam logic [4:0] EXC_CODE_RI  = 5'd10;
    localparam logic [4:0] EXC_CODE_OV  = 5'd12;

    // Bit that re-enables interrupts when set in SR
    localparam logic [31:0] SR_IE_MASK = 32'h0000_0001;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXC_EPC  = 3'd1,
        ST_EXC_JUMP = 3'd2,
        ST_RET_RD   = 3'd3,
        ST_RET_WR   = 3'd4,
        ST_RET_JUMP = 3'd5
    } exc_state_e;

    // Highest set request bit wins: [2] RI, [1] SYS, [0] OV.
    // Returns INT when no synchronous request is present.
    function automatic logic [4:0] exc_code_of(input logic [2:0] req);
        logic [4:0] code;
        code = EXC_CODE_INT;
        if (req[2]) begin
            code = EXC_CODE_RI;
        end else if (req[1]) begin
            code = EXC_CODE_SYS;
        end else if (req[0]) begin
            code = EXC_CODE_OV;
        end
        return code;
    endfunction

endpackage

// File: rtl/coco_exc_prio.sv
// -----------------------------------------------------------------------------
// coco_exc_prio
// Combinational priority encoder for exception entry.
// Synchronous exceptions beat the interrupt line; among the synchronous
// exceptions the highest set bit of ExcReq wins.
//
// Ports:
//   ExcReq  in  3 : [2] reserved instr, [1] syscall, [0] overflow
//   Inter   in  1 : CP0 interrupt request
//   Valid   out 1 : some exception or interrupt is requested
//   Code    out 5 : exception code of the winning request
// -----------------------------------------------------------------------------
module coco_exc_prio
    import coco_cp0_pkg::*;
(
    input  logic [2:0] ExcReq,
    input  logic       Inter,
    output logic       Valid,
    output logic [4:0] Code
);

    logic sync_req;

    assign sync_req = |ExcReq;
    assign Valid    = sync_req | Inter;

    // An interrupt alone maps to INT, which is also exc_code_of's default.
    assign Code = sync_req ? exc_code_of(ExcReq) : EXC_CODE_INT;

endmodule

// File: rtl/coco_exc_ctrl.sv
// -----------------------------------------------------------------------------
// coco_exc_ctrl
// Exception/interrupt sequencer and CP0 access arbiter for the Coco MIPS core.
//
// Exception entry : IDLE -> EXC_EPC (write EPC, ExcEnter) -> EXC_JUMP (vector)
// eret            : IDLE -> RET_RD (read SR) -> RET_WR (SR | 1) -> RET_JUMP (EPC)
// In IDLE the pipeline's mtc0/mfc0 accesses pass straight through to CP0.
//
// Optional feature macro: COCO_EXC_BD_EN
//   defined   : delay-slot faults save EPC = InstrPC - 4, ExcBD holds the
//               InstrBD flag latched at exception entry.
//   undefined : EPC = InstrPC, InstrBD ignored, ExcBD tied to 0.
//
// Parameters:
//   VECTOR            : exception handler entry address
//
// Ports:
//   Clk, Reset_n      : clock, asynchronous active-low reset
//   InstrValid        : memory-stage instruction commits this cycle
//   InstrPC, InstrBD  : its PC and branch-delay-slot flag
//   ExcReq, Inter     : synchronous exception flags, CP0 interrupt request
//   EretReq           : committing instruction is eret
//   Mtc0We/Idx/Data   : pipeline CP0 write request
//   Mfc0Idx           : pipeline CP0 read index
//   Cp0DOut, Cp0Epc   : CP0 read data, CP0 EPC register
//   Cp0Idx/DIn/We     : CP0 access port
//   ExcEnter, ExcCode : CP0 exception entry strobe and code
//   Stall, Flush      : pipeline hold / kill younger instructions
//   PcRedirect/Target : PC load request
//   ExcBD             : latched delay-slot flag
// -----------------------------------------------------------------------------
module coco_exc_ctrl
    import coco_cp0_pkg::*;
#(
    parameter logic [31:0] VECTOR = 32'h0000_4180
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        InstrValid,
    input  logic [31:0] InstrPC,
    input  logic        InstrBD,
    input  logic [2:0]  ExcReq,
    input  logic        Inter,
    input  logic        EretReq,
    input  logic        Mtc0We,
    input  logic [4:0]  Mtc0Idx,
    input  logic [31:0] Mtc0Data,
    input  logic [4:0]  Mfc0Idx,
    input  logic [31:0] Cp0DOut,
    input  logic [31:0] Cp0Epc,
    output logic [4:0]  Cp0Idx,
    output logic [31:0] Cp0DIn,
    output logic        Cp0We,
    output logic        ExcEnter,
    output logic [4:0]  ExcCode,
    output logic        Stall,
    output logic        Flush,
    output logic        PcRedirect,
    output logic [31:0] PcTarget,
    output logic        ExcBD
);

    exc_state_e  state_reg;
    logic [4:0]  code_reg;
    logic [31:0] epc_reg;
    logic [31:0] sr_reg;
    logic        bd_reg;

    logic        prio_valid;
    logic [4:0]  prio_code;
    logic        is_idle;
    logic        take_exc;
    logic        take_eret;
    logic [31:0] epc_next;
    logic        bd_next;

    coco_exc_prio u_prio (
        .ExcReq (ExcReq),
        .Inter  (Inter),
        .Valid  (prio_valid),
        .Code   (prio_code)
    );

    assign is_idle = (state_reg == ST_IDLE);

    // Events are only considered for a committing instruction in IDLE;
    // anything arriving while a sequence runs is dropped, not queued.
    assign take_exc  = is_idle && InstrValid && prio_valid;
    assign take_eret = is_idle && InstrValid && !prio_valid && EretReq;

`ifdef COCO_EXC_BD_EN
    // A fault in a delay slot restarts at the branch so the branch re-executes.
    assign epc_next = InstrBD ? (InstrPC - 32'd4) : InstrPC;
    assign bd_next  = InstrBD;
`else
    logic unused_instr_bd;
    assign unused_instr_bd = InstrBD;
    assign epc_next        = InstrPC;
    assign bd_next         = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Sequencer state and latched context
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
            code_reg  <= EXC_CODE_INT;
            epc_reg   <= 32'd0;
            sr_reg    <= 32'd0;
            bd_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (take_exc) begin
                        state_reg <= ST_EXC_EPC;
                        code_reg  <= prio_code;
                        epc_reg   <= epc_next;
                        bd_reg    <= bd_next;
                    end else if (take_eret) begin
                        state_reg <= ST_RET_RD;
                    end
                end
                ST_EXC_EPC: begin
                    state_reg <= ST_EXC_JUMP;
                end
                ST_EXC_JUMP: begin
                    state_reg <= ST_IDLE;
                end
                ST_RET_RD: begin
                    // Snapshot SR so the write-back only flips the IE bit.
                    sr_reg    <= Cp0DOut;
                    state_reg <= ST_RET_WR;
                end
                ST_RET_WR: begin
                    state_reg <= ST_RET_JUMP;
                end
                ST_RET_JUMP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode: Moore outputs from state_reg outside IDLE, combinational
    // pass-through in IDLE. The pass-through is gated by Reset_n so that all
    // outputs drop to 0 while reset is asserted.
    // -------------------------------------------------------------------------
    always_comb begin
        Cp0Idx     = 5'd0;
        Cp0DIn     = 32'd0;
        Cp0We      = 1'b0;
        ExcEnter   = 1'b0;
        ExcCode    = 5'd0;
        Stall      = 1'b0;
        Flush      = 1'b0;
        PcRedirect = 1'b0;
        PcTarget   = 32'd0;

        case (state_reg)
            ST_IDLE: begin
                if (Reset_n) begin
                    Cp0Idx = Mtc0We ? Mtc0Idx : Mfc0Idx;
                    Cp0DIn = Mtc0Data;
                    // The mtc0 of a faulting instruction must not retire.
                    Cp0We  = Mtc0We && !take_exc;
                end
            end
            ST_EXC_EPC: begin
                Cp0We    = 1'b1;
                Cp0Idx   = CP0_IDX_EPC;
                Cp0DIn   = epc_reg;
                ExcEnter = 1'b1;
                ExcCode  = code_reg;
                Flush    = 1'b1;
                Stall    = 1'b1;
            end
            ST_EXC_JUMP: begin
                PcRedirect = 1'b1;
                PcTarget   = VECTOR;
                Flush      = 1'b1;
                Stall      = 1'b1;
            end
            ST_RET_RD: begin
                Cp0Idx = CP0_IDX_SR;
                Flush  = 1'b1;
                Stall  = 1'b1;
            end
            ST_RET_WR: begin
                Cp0We  = 1'b1;
                Cp0Idx = CP0_IDX_SR;
                Cp0DIn = sr_reg | SR_IE_MASK;
                Stall  = 1'b1;
            end
            ST_RET_JUMP: begin
                PcRedirect = 1'b1;
                PcTarget   = Cp0Epc;
                Stall      = 1'b1;
            end
            default: begin
                Stall = 1'b1;
            end
        endcase
    end

    assign ExcBD = bd_reg;

endmodule

// File: tb/tb_coco_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coco_exc_ctrl
// Directed self-checking bench for coco_exc_ctrl. Inputs change 1 ns after
// the rising edge, outputs are checked 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_coco_exc_ctrl;

    logic        Clk;
    logic        Reset_n;
    logic        InstrValid;
    logic [31:0] InstrPC;
    logic        InstrBD;
    logic [2:0]  ExcReq;
    logic        Inter;
    logic        EretReq;
    logic        Mtc0We;
    logic [4:0]  Mtc0Idx;
    logic [31:0] Mtc0Data;
    logic [4:0]  Mfc0Idx;
    logic [31:0] Cp0DOut;
    logic [31:0] Cp0Epc;
    logic [4:0]  Cp0Idx;
    logic [31:0] Cp0DIn;
    logic        Cp0We;
    logic        ExcEnter;
    logic [4:0]  ExcCode;
    logic        Stall;
    logic        Flush;
    logic        PcRedirect;
    logic [31:0] PcTarget;
    logic        ExcBD;

    int n_checks = 0;
    int n_errors = 0;

    coco_exc_ctrl #(.VECTOR(32'h0000_4180)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .InstrValid (InstrValid),
        .InstrPC    (InstrPC),
        .InstrBD    (InstrBD),
        .ExcReq     (ExcReq),
        .Inter      (Inter),
        .EretReq    (EretReq),
        .Mtc0We     (Mtc0We),
        .Mtc0Idx    (Mtc0Idx),
        .Mtc0Data   (Mtc0Data),
        .Mfc0Idx    (Mfc0Idx),
        .Cp0DOut    (Cp0DOut),
        .Cp0Epc     (Cp0Epc),
        .Cp0Idx     (Cp0Idx),
        .Cp0DIn     (Cp0DIn),
        .Cp0We      (Cp0We),
        .ExcEnter   (ExcEnter),
        .ExcCode    (ExcCode),
        .Stall      (Stall),
        .Flush      (Flush),
        .PcRedirect (PcRedirect),
        .PcTarget   (PcTarget),
        .ExcBD      (ExcBD)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        InstrValid = 1'b0;
        InstrPC    = 32'd0;
        InstrBD    = 1'b0;
        ExcReq     = 3'b000;
        Inter      = 1'b0;
        EretReq    = 1'b0;
        Mtc0We     = 1'b0;
        Mtc0Idx    = 5'd0;
        Mtc0Data   = 32'd0;
        Mfc0Idx    = 5'd0;
    endtask

    logic [31:0] exp_bd_epc;
    logic [31:0] exp_bd_flag;

    initial begin
        clear_inputs();
        Cp0DOut = 32'd0;
        Cp0Epc  = 32'd0;
        Reset_n = 1'b0;

`ifdef COCO_EXC_BD_EN
        exp_bd_epc  = 32'h0000_3004;
        exp_bd_flag = 32'd1;
`else
        exp_bd_epc  = 32'h0000_3008;
        exp_bd_flag = 32'd0;
`endif

        // ---- reset state --------------------------------------------------
        Mtc0We = 1'b1;
        Mtc0Idx = 5'd12;
        tick();
        #1;
        check("rst_cp0we", {31'd0, Cp0We}, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_redirect", {31'd0, PcRedirect}, 32'd0);
        check("rst_excbd", {31'd0, ExcBD}, 32'd0);
        Mtc0We = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();

        // ---- syscall beats overflow ---------------------------------------
        InstrValid = 1'b1;
        InstrPC    = 32'h0000_3000;
        ExcReq     = 3'b011;
        #1;
        check("sys_idle_stall", {31'd0, Stall}, 32'd0);
        tick();
        clear_inputs();
        #1;
        check("sys_enter", {31'd0, ExcEnter}, 32'd1);
        check("sys_code", {27'd0, ExcCode}, 32'd8);
        check("sys_we", {31'd0, Cp0We}, 32'd1);
        check("sys_idx", {27'd0, Cp0Idx}, 32'd14);
        check("sys_epc", Cp0DIn, 32'h0000_3000);
        check("sys_flush", {31'd0, Flush}, 32'd1);
        check("sys_stall", {31'd0, Stall}, 32'd1);
        tick();
        #1;
        check("sys_redirect", {31'd0, PcRedirect}, 32'd1);
        check("sys_target", PcTarget, 32'h0000_4180);
        check("sys_jump_code", {27'd0, ExcCode}, 32'd0);
        tick();
        #1;
        check("sys_back_idle", {31'd0, Stall}, 32'd0);

        // ---- interrupt drops a simultaneous mtc0 --------------------------
        Mtc0We   = 1'b1;
        Mtc0Idx  = 5'd12;
        Mtc0Data = 32'hDEAD_BEEF;
        Mfc0Idx  = 5'd3;
        #1;
        check("mtc0_pass_we", {31'd0, Cp0We}, 32'd1);
        check("mtc0_pass_idx", {27'd0, Cp0Idx}, 32'd12);
        check("mtc0_pass_data", Cp0DIn, 32'hDEAD_BEEF);
        Mtc0We = 1'b0;
        #1;
        check("mfc0_pass_idx", {27'd0, Cp0Idx}, 32'd3);
        Mtc0We     = 1'b1;
        InstrValid = 1'b1;
        InstrPC    = 32'h0000_2000;
        Inter      = 1'b1;
        #1;
        check("int_drop_we", {31'd0, Cp0We}, 32'd0);
        tick();
        clear_inputs();
        #1;
        check("int_enter", {31'd0, ExcEnter}, 32'd1);
        check("int_code", {27'd0, ExcCode}, 32'd0);
        check("int_epc", Cp0DIn, 32'h0000_2000);
        tick();
        tick();

        // ---- reserved instruction wins over everything --------------------
        InstrValid = 1'b1;
        InstrPC    = 32'h0000_1000;
        ExcReq     = 3'b111;
        Inter      = 1'b1;
        EretReq    = 1'b1;
        tick();
        clear_inputs();
        #1;
        check("ri_code", {27'd0, ExcCode}, 32'd10);
        tick();
        tick();

        // ---- overflow in a delay slot -------------------------------------
        InstrValid = 1'b1;
        InstrBD    = 1'b1;
        InstrPC    = 32'h0000_3008;
        ExcReq     = 3'b001;
        tick();
        clear_inputs();
        #1;
        check("bd_code", {27'd0, ExcCode}, 32'd12);
        check("bd_epc", Cp0DIn, exp_bd_epc);
        check("bd_flag", {31'd0, ExcBD}, exp_bd_flag);
        tick();
        tick();
        #1;
        check("bd_flag_hold", {31'd0, ExcBD}, exp_bd_flag);

        // ---- eret, with requests during the sequence ignored --------------
        InstrValid = 1'b1;
        EretReq    = 1'b1;
        tick();
        clear_inputs();
        InstrValid = 1'b1;
        ExcReq     = 3'b100;
        Mtc0We     = 1'b1;
        Cp0DOut    = 32'h0000_FC00;
        Cp0Epc     = 32'h0000_3004;
        #1;
        check("ret_rd_idx", {27'd0, Cp0Idx}, 32'd12);
        check("ret_rd_we", {31'd0, Cp0We}, 32'd0);
        check("ret_rd_stall", {31'd0, Stall}, 32'd1);
        check("ret_rd_flush", {31'd0, Flush}, 32'd1);
        tick();
        Cp0DOut = 32'h1234_5678;
        #1;
        check("ret_wr_we", {31'd0, Cp0We}, 32'd1);
        check("ret_wr_idx", {27'd0, Cp0Idx}, 32'd12);
        check("ret_wr_data", Cp0DIn, 32'h0000_FC01);
        check("ret_wr_enter", {31'd0, ExcEnter}, 32'd0);
        check("ret_wr_stall", {31'd0, Stall}, 32'd1);
        tick();
        #1;
        check("ret_jump_redirect", {31'd0, PcRedirect}, 32'd1);
        check("ret_jump_target", PcTarget, 32'h0000_3004);
        check("ret_jump_stall", {31'd0, Stall}, 32'd1);
        tick();
        clear_inputs();
        #1;
        check("ret_idle_stall", {31'd0, Stall}, 32'd0);
        check("ret_idle_we", {31'd0, Cp0We}, 32'd0);

        // ---- request without a committing instruction ---------------------
        ExcReq = 3'b010;
        Inter  = 1'b1;
        #1;
        check("nv_we", {31'd0, Cp0We}, 32'd0);
        tick();
        #1;
        check("nv_stall", {31'd0, Stall}, 32'd0);
        check("nv_enter", {31'd0, ExcEnter}, 32'd0);
        clear_inputs();

        // ---- reset during EXC_JUMP ----------------------------------------
        InstrValid = 1'b1;
        InstrPC    = 32'h0000_5000;
        ExcReq     = 3'b010;
        tick();
        clear_inputs();
        tick();
        #1;
        check("rj_redirect_pre", {31'd0, PcRedirect}, 32'd1);
        Reset_n = 1'b0;
        #1;
        check("rj_redirect", {31'd0, PcRedirect}, 32'd0);
        check("rj_stall", {31'd0, Stall}, 32'd0);
        check("rj_flush", {31'd0, Flush}, 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        #1;
        check("rj_idle_stall", {31'd0, Stall}, 32'd0);
        check("rj_idle_enter", {31'd0, ExcEnter}, 32'd0);
        Mtc0We  = 1'b1;
        Mtc0Idx = 5'd13;
        #1;
        check("rj_idle_pass", {27'd0, Cp0Idx}, 32'd13);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
